approx_error_sweeper: RTL and testbench
=======================================

Name: approx_error_sweeper

Overview:
- Sequential verification controller for one approximate combinational circuit (an approximated abs_diff candidate) instantiated next to its exact reference.
- On start, drives every input vector 0..2^N_IN-1 to both circuits and compares their outputs as unsigned integers.
- Reports worst-case absolute error, the first vector that produced it, and how many vectors exceed the error threshold ET.
- Gives a pass/fail verdict against ET, so hardware sign-off of a candidate needs no software sweep.

Parameters:
- N_IN, 4, input width of the circuits under test; sweep length is 2^N_IN.
- N_OUT, 3, output width of both circuits (unsigned integer, out0 = LSB).
- ET, 3, error threshold; a vector violates when |exact - approx| > ET.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- abort  in  1  cancel a running sweep.
- vec_o  out  N_IN  input vector driven to both circuits (in0 = bit 0).
- exact_i  in  N_OUT  exact circuit output for vec_o, combinational, same cycle.
- approx_i  in  N_OUT  approximate circuit output for vec_o, combinational, same cycle.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse; results valid.
- pass  out  1  max_err <= ET; valid from done until the next start.
- max_err  out  N_OUT  worst-case absolute error.
- wce_vec  out  N_IN  first vector reaching max_err.
- err_cnt  out  N_IN+1  number of vectors with error > ET (range 0..2^N_IN).

Behaviour:
- Reset, asynchronous, rst_n low:
  - State IDLE.
  - vec_o, max_err, wce_vec and err_cnt clear to 0.
  - busy, done and pass clear to 0.
  - Reset mid-sweep discards all progress.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at an edge enters RUN.
  - The same edge sets vec_o=0 and clears max_err, wce_vec, err_cnt and pass.
- RUN, stage 1:
  - Each cycle, err = |exact_i - approx_i|, computed unsigned at N_OUT bits with no overflow.
  - err and the vec_o tag are registered with a stage-valid bit.
  - vec_o then increments.
  - The cycle with vec_o = 2^N_IN-1 moves to DRAIN; vec_o holds its last value, no wrap.
- Stage 2 (RUN and DRAIN): on each valid registered error:
  - If err_q > max_err: max_err <= err_q and wce_vec <= tag. Strictly greater only, so the first occurrence wins ties.
  - If err_q > ET: err_cnt increments.
  - Stage-1 register and this update are the only pipeline; total latency 1 cycle per vector after sampling.
- DRAIN:
  - One cycle that processes the final vector's error.
  - Then DONE.
- DONE:
  - done=1 and pass = (max_err <= ET) for exactly one cycle.
  - Then IDLE.
  - Results and pass hold until the next accepted start.
- Timing: start sampled at edge 0 -> RUN during cycles 1..2^N_IN -> DRAIN at cycle 2^N_IN+1 -> done high at cycle 2^N_IN+2 (cycle 18 for N_IN=4).
- start while busy or in DONE is ignored.
- abort=1 in RUN or DRAIN:
  - Returns to IDLE at the next edge with no done pulse.
  - pass=0; statistics hold their partial values and are invalid.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the state transition in the same cycle.
- Simultaneous start and abort in IDLE: start is accepted.

Test Plan:
- approx_i = exact_i for all 16 vectors, start pulse -> done at cycle 18; max_err=0, err_cnt=0, wce_vec=0, pass=1; busy high cycles 1..17.
- Exact = |in[1:0]-in[3:2]|, approx equal except vector 5 where approx = exact^3'b100 -> max_err=4, wce_vec=5, err_cnt=1, pass=0.
- Exact abs_diff as above, approx_i tied to 0 -> max_err=3, wce_vec=3 (first vector with error 3, ahead of 12), err_cnt=0, pass=1.
- abort asserted at cycle 8 -> IDLE at cycle 9, no done, pass=0; a new start then gives a full 18-cycle sweep with correct results.
- start re-pulsed at cycles 3 and 17 during a sweep -> ignored; single done at cycle 18; the next start after done is accepted.
- rst_n low asynchronously at cycle 10 -> all outputs 0 immediately, state IDLE; start after release gives a correct sweep.

Source files
------------

// File: rtl/approx_error_sweeper.sv
// approx_error_sweeper
// Sweeps every input vector 0..2^N_IN-1 through an approximate circuit and
// its exact reference, which sit outside this block, and compares their
// outputs. It reports the worst-case absolute error, the first vector that
// reached it, the number of vectors whose error exceeds ET, and a pass verdict.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request a sweep (sampled only in IDLE)
//   abort     cancel a running sweep (RUN or DRAIN)
//   vec_o     input vector driven to both circuits
//   exact_i   exact circuit output for vec_o (combinational, same cycle)
//   approx_i  approximate circuit output for vec_o (combinational, same cycle)
//   busy      high in RUN and DRAIN
//   done      one-cycle pulse when the results are valid
//   pass      max_err <= ET; held from done until the next start
//   max_err   worst-case absolute error
//   wce_vec   first vector that reached max_err
//   err_cnt   number of vectors whose error is greater than ET
module approx_error_sweeper #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_o,
  input  logic [N_OUT-1:0]  exact_i,
  input  logic [N_OUT-1:0]  approx_i,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_OUT-1:0]  max_err,
  output logic [N_IN-1:0]   wce_vec,
  output logic [N_IN:0]     err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]  VEC_ONE  = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]    CNT_ONE  = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_OUT-1:0] ET_V     = N_OUT'(ET);

  state_t             state_q, state_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic               v1_q, v1_d;
  logic [N_OUT-1:0]   err1_q, err1_d;
  logic [N_IN-1:0]    tag1_q, tag1_d;
  logic [N_OUT-1:0]   max_err_q, max_err_d;
  logic [N_IN-1:0]    wce_q, wce_d;
  logic [N_IN:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [N_OUT-1:0]   err_s;
  logic               active_s;

  // Next-state logic: stage-1 error capture, stage-2 statistics, FSM and abort.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    max_err_d = max_err_q;
    wce_d     = wce_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    v1_d      = 1'b0;
    tag1_d    = vec_q;
    active_s  = (state_q == S_RUN) || (state_q == S_DRAIN);

    // Ordering the subtraction keeps the difference within N_OUT bits.
    if (exact_i >= approx_i) begin
      err_s = exact_i - approx_i;
    end else begin
      err_s = approx_i - exact_i;
    end
    err1_d = err_s;

    // Stage 2: strictly-greater compare so the first vector wins ties.
    if (active_s && v1_q) begin
      if (err1_q > max_err_q) begin
        max_err_d = err1_q;
        wce_d     = tag1_q;
      end else begin
        max_err_d = max_err_q;
      end
      if (err1_q > ET_V) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          vec_d     = {N_IN{1'b0}};
          max_err_d = {N_OUT{1'b0}};
          wce_d     = {N_IN{1'b0}};
          cnt_d     = {(N_IN+1){1'b0}};
          pass_d    = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        v1_d   = 1'b1;
        busy_d = 1'b1;
        // The last vector holds on vec_o rather than wrapping.
        if (vec_q == VEC_LAST) begin
          state_d = S_DRAIN;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        // Verdict uses the statistics including the final vector's update.
        pass_d  = (max_err_d <= ET_V);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides the normal transition; statistics keep partial values.
    if (abort && active_s) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      v1_d    = 1'b0;
      pass_d  = 1'b0;
    end else begin
      v1_d = v1_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      vec_q     <= {N_IN{1'b0}};
      v1_q      <= 1'b0;
      err1_q    <= {N_OUT{1'b0}};
      tag1_q    <= {N_IN{1'b0}};
      max_err_q <= {N_OUT{1'b0}};
      wce_q     <= {N_IN{1'b0}};
      cnt_q     <= {(N_IN+1){1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      v1_q      <= v1_d;
      err1_q    <= err1_d;
      tag1_q    <= tag1_d;
      max_err_q <= max_err_d;
      wce_q     <= wce_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign vec_o   = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign max_err = max_err_q;
  assign wce_vec = wce_q;
  assign err_cnt = cnt_q;

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Directed bench for approx_error_sweeper. The exact circuit is modelled as
// |in[1:0] - in[3:2]|, and a mode selects the approximate circuit's behaviour.
module tb_approx_error_sweeper;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] vec_o;
  logic [2:0] exact_i;
  logic [2:0] approx_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] max_err;
  logic [3:0] wce_vec;
  logic [4:0] err_cnt;

  int n_checks;
  int n_fail;
  int mode;

  approx_error_sweeper #(.N_IN(4), .N_OUT(3), .ET(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .vec_o    (vec_o),
    .exact_i  (exact_i),
    .approx_i (approx_i),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .max_err  (max_err),
    .wce_vec  (wce_vec),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Circuits under test: mode 0 exact copy, mode 1 flips bit 2 at vector 5,
  // mode 2 approximate output tied to zero.
  always_comb begin
    logic [1:0] a;
    logic [1:0] b;
    a = vec_o[1:0];
    b = vec_o[3:2];
    exact_i = (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
    approx_i = exact_i;
    case (mode)
      1: approx_i = (vec_o == 4'd5) ? (exact_i ^ 3'b100) : exact_i;
      2: approx_i = 3'd0;
      default: approx_i = exact_i;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One sweep from a start pulse; cycle c is the cycle after edge c-1,
  // where edge 0 is the edge that samples start.
  task automatic sweep(input int m, input int abort_cyc, input int rs_a, input int rs_b,
                       input int exp_max, input int exp_wce, input int exp_cnt,
                       input int exp_pass);
    int exp_busy;
    int exp_done;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == rs_a) || (c == rs_b);
      abort = (c == abort_cyc);
      if (abort_cyc > 0) begin
        exp_busy = (c <= abort_cyc) ? 1 : 0;
        exp_done = 0;
      end else begin
        exp_busy = (c <= 17) ? 1 : 0;
        exp_done = (c == 18) ? 1 : 0;
      end
      check_eq($sformatf("busy_c%0d", c), {31'd0, busy}, exp_busy);
      check_eq($sformatf("done_c%0d", c), {31'd0, done}, exp_done);
      if (abort_cyc == 0 && c <= 17) begin
        check_eq($sformatf("vec_c%0d", c), {28'd0, vec_o}, (c <= 16) ? c - 1 : 15);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check_eq("pass", {31'd0, pass}, exp_pass);
    if (abort_cyc == 0) begin
      check_eq("max_err", {29'd0, max_err}, exp_max);
      check_eq("wce_vec", {28'd0, wce_vec}, exp_wce);
      check_eq("err_cnt", {27'd0, err_cnt}, exp_cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mode     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_vec", {28'd0, vec_o}, 0);
    check_eq("rst_busy", {31'd0, busy}, 0);
    check_eq("rst_done", {31'd0, done}, 0);
    check_eq("rst_pass", {31'd0, pass}, 0);
    check_eq("rst_max", {29'd0, max_err}, 0);
    check_eq("rst_wce", {28'd0, wce_vec}, 0);
    check_eq("rst_cnt", {27'd0, err_cnt}, 0);
    rst_n = 1'b1;

    // Identical circuits.
    sweep(0, 0, -1, -1, 0, 0, 0, 1);
    // Single error of 4 at vector 5.
    sweep(1, 0, -1, -1, 4, 5, 1, 0);
    // Approx tied low: max error 3 first at vector 3, ahead of vector 12.
    sweep(2, 0, -1, -1, 3, 3, 0, 1);
    // Abort at cycle 8, then a full sweep.
    sweep(1, 8, -1, -1, 0, 0, 0, 0);
    sweep(1, 0, -1, -1, 4, 5, 1, 0);
    // Start re-pulsed mid-sweep and during DRAIN is ignored.
    sweep(0, 0, 3, 17, 0, 0, 0, 1);
    // Next start after done is accepted.
    sweep(2, 0, -1, -1, 3, 3, 0, 1);

    // Asynchronous reset in the middle of a sweep.
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_vec", {28'd0, vec_o}, 0);
    check_eq("arst_busy", {31'd0, busy}, 0);
    check_eq("arst_done", {31'd0, done}, 0);
    check_eq("arst_pass", {31'd0, pass}, 0);
    check_eq("arst_max", {29'd0, max_err}, 0);
    check_eq("arst_wce", {28'd0, wce_vec}, 0);
    check_eq("arst_cnt", {27'd0, err_cnt}, 0);
    @(negedge clk);
    check_eq("arst_busy_held", {31'd0, busy}, 0);
    rst_n = 1'b1;
    sweep(1, 0, -1, -1, 4, 5, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
